// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS core-to-Avalon bus sequencer.
package mips_bus_pkg;

    // Access width requested by the core.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    // Sequencer states: one request is in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUS       = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    // Request fields captured at the handshake and held for the whole transaction.
    typedef struct packed {
        logic        write;
        size_e       size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Largest supported read latency; sizes the latency counter.
    localparam int unsigned MAX_READ_LATENCY = 3;

    // True when the low address bits do not match the natural alignment of the access.
    function automatic logic is_misaligned(size_e size, logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return |off;
            default: return 1'b0;
        endcase
    endfunction

    // A request is answered with an error, without touching the bus, when this is true.
    function automatic logic is_bad_request(size_e size, logic [1:0] off, logic align_check);
        return (size == SZ_RSVD) || (align_check && is_misaligned(size, off));
    endfunction

endpackage

// File: rtl/mips_bus_sequencer_if.sv
// Core request/response channel plus Avalon-MM master signals in one bundle.
interface mips_bus_sequencer_if;

    // Core request side
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Core response side
    logic        rsp_valid;
    logic        rsp_error;
    logic [31:0] rsp_rdata;

    // Avalon-MM side
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    // The sequencer: accepts core requests and masters the Avalon bus.
    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  waitrequest, readdata,
        output req_ready, rsp_valid, rsp_error, rsp_rdata,
        output address, write, read, writedata, byteenable
    );

    // The environment: the core issuing requests and the Avalon slave answering.
    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output waitrequest, readdata,
        input  req_ready, rsp_valid, rsp_error, rsp_rdata,
        input  address, write, read, writedata, byteenable
    );

endinterface

// File: rtl/mips_bus_sequencer_lane.sv
// Byte-lane steering for stores and load extraction/extension (purely combinational).
module mips_bus_lane
    import mips_bus_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Per-lane enable and store data; narrow data is replicated so any lane can take it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign byteenable[gi] = (size == SZ_WORD)
                                  | ((size == SZ_HALF) & (offset[1] == LANE[1]))
                                  | ((size == SZ_BYTE) & (offset == LANE));

            assign writedata[8*gi +: 8] = (size == SZ_WORD) ? wdata[8*gi +: 8]
                                        : (size == SZ_HALF) ? wdata[8*(gi%2) +: 8]
                                        :                     wdata[7:0];
        end
    endgenerate

    // Pick the addressed byte/half out of the bus word and extend it to 32 bits.
    always_comb begin
        rdata_ext = rdata;
        byte_sel  = rdata[{offset, 3'b000} +: 8];
        half_sel  = rdata[{offset[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: rdata_ext = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_ext = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mips_bus_sequencer.sv
// Avalon-MM master turning single core fetch/load/store requests into one bus transaction each.
module mips_bus_sequencer
    import mips_bus_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 0,
    parameter int unsigned MAX_WAIT     = 0,
    parameter bit          ALIGN_CHECK  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_bus_sequencer_if.master bus
);

    // Index of the last WAIT_DATA cycle; unused when reads complete in BUS.
    localparam logic [1:0] LAT_LAST = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

    state_e      state_reg, state_next;
    req_t        req_reg;
    logic        err_reg, err_next;
    logic [31:0] rdata_reg;
    logic [1:0]  lat_cnt_reg, lat_cnt_next;
    logic [31:0] wait_cnt_reg, wait_cnt_next;
    logic        live_reg;
    logic        accept;
    logic        capture;
    logic        in_bus;
    logic        in_resp;

    logic [3:0]  lane_be;
    logic [31:0] lane_wd;
    logic [31:0] lane_rdata;

    mips_bus_lane u_lane (
        .size       (req_reg.size),
        .offset     (req_reg.addr[1:0]),
        .sign_ext   (req_reg.sign),
        .wdata      (req_reg.wdata),
        .rdata      (rdata_reg),
        .byteenable (lane_be),
        .writedata  (lane_wd),
        .rdata_ext  (lane_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic plus the strobes that load the request latch and capture read data.
    always_comb begin
        state_next    = state_reg;
        err_next      = err_reg;
        lat_cnt_next  = lat_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        accept        = 1'b0;
        capture       = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (live_reg && bus.req_valid) begin
                    accept        = 1'b1;
                    err_next      = is_bad_request(size_e'(bus.req_size), bus.req_addr[1:0], ALIGN_CHECK);
                    lat_cnt_next  = 2'd0;
                    wait_cnt_next = 32'd0;
                    state_next    = err_next ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (!bus.waitrequest) begin
                    if (req_reg.write) begin
                        state_next = ST_RESP;
                    end else if (READ_LATENCY == 0) begin
                        capture    = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        state_next = ST_WAIT_DATA;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg + 32'd1;
                    if (MAX_WAIT != 0 && wait_cnt_next == MAX_WAIT) begin
                        err_next   = 1'b1;
                        state_next = ST_RESP;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (lat_cnt_reg == LAT_LAST) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 2'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, error flag, counters and captured read word.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_reg      <= '0;
            err_reg      <= 1'b0;
            rdata_reg    <= 32'd0;
            lat_cnt_reg  <= 2'd0;
            wait_cnt_reg <= 32'd0;
            live_reg     <= 1'b0;
        end else begin
            live_reg     <= 1'b1;
            err_reg      <= err_next;
            lat_cnt_reg  <= lat_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                req_reg.write <= bus.req_write;
                req_reg.size  <= size_e'(bus.req_size);
                req_reg.sign  <= bus.req_signed;
                req_reg.addr  <= bus.req_addr;
                req_reg.wdata <= bus.req_wdata;
            end
            if (capture) begin
                rdata_reg <= bus.readdata;
            end
        end
    end

    // Outputs depend only on registered state, never directly on the core request inputs.
    assign in_bus  = (state_reg == ST_BUS);
    assign in_resp = (state_reg == ST_RESP);

    assign bus.req_ready  = (state_reg == ST_IDLE) && live_reg;
    assign bus.rsp_valid  = in_resp;
    assign bus.rsp_error  = in_resp && err_reg;
    assign bus.rsp_rdata  = (in_resp && !err_reg && !req_reg.write) ? lane_rdata : 32'd0;

    assign bus.read       = in_bus && !req_reg.write;
    assign bus.write      = in_bus && req_reg.write;
    assign bus.address    = in_bus ? {req_reg.addr[31:2], 2'b00} : 32'd0;
    assign bus.byteenable = in_bus ? lane_be : 4'd0;
    assign bus.writedata  = in_bus ? lane_wd : 32'd0;

endmodule

// File: tb/tb_mips_bus_sequencer.sv
// Bench: three parameterisations driven by directed and random requests, checked each cycle
// against a transaction-level timeline model.
module tb_mips_bus_sequencer;

    localparam int NCFG = 3;

    function automatic int unsigned rl_of(int i);
        case (i) 0: return 2; 1: return 0; default: return 1; endcase
    endfunction
    function automatic int unsigned mw_of(int i);
        case (i) 0: return 4; 1: return 0; default: return 2; endcase
    endfunction
    function automatic bit ac_of(int i);
        case (i) 0: return 1'b1; 1: return 1'b0; default: return 1'b1; endcase
    endfunction

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Stimulus
    logic        req_valid   [NCFG];
    logic        req_write   [NCFG];
    logic [1:0]  req_size    [NCFG];
    logic        req_signed  [NCFG];
    logic [31:0] req_addr    [NCFG];
    logic [31:0] req_wdata   [NCFG];
    logic        waitrequest [NCFG];
    logic [31:0] readdata    [NCFG];

    // Observed outputs
    logic        o_ready     [NCFG];
    logic        o_rsp_valid [NCFG];
    logic        o_rsp_error [NCFG];
    logic [31:0] o_rdata     [NCFG];
    logic        o_read      [NCFG];
    logic        o_write     [NCFG];
    logic [31:0] o_address   [NCFG];
    logic [3:0]  o_be        [NCFG];
    logic [31:0] o_wd        [NCFG];

    // Model expectations
    logic        exp_ready     [NCFG];
    logic        exp_rsp_valid [NCFG];
    logic        exp_rsp_error [NCFG];
    logic [31:0] exp_rdata     [NCFG];
    logic        exp_read      [NCFG];
    logic        exp_write     [NCFG];
    logic [31:0] exp_address   [NCFG];
    logic [3:0]  exp_be        [NCFG];
    logic [31:0] exp_wd        [NCFG];
    logic        chk_en        [NCFG];

    generate
        for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
            mips_bus_sequencer_if bus_g ();
            assign bus_g.req_valid   = req_valid[gi];
            assign bus_g.req_write   = req_write[gi];
            assign bus_g.req_size    = req_size[gi];
            assign bus_g.req_signed  = req_signed[gi];
            assign bus_g.req_addr    = req_addr[gi];
            assign bus_g.req_wdata   = req_wdata[gi];
            assign bus_g.waitrequest = waitrequest[gi];
            assign bus_g.readdata    = readdata[gi];
            assign o_ready[gi]     = bus_g.req_ready;
            assign o_rsp_valid[gi] = bus_g.rsp_valid;
            assign o_rsp_error[gi] = bus_g.rsp_error;
            assign o_rdata[gi]     = bus_g.rsp_rdata;
            assign o_read[gi]      = bus_g.read;
            assign o_write[gi]     = bus_g.write;
            assign o_address[gi]   = bus_g.address;
            assign o_be[gi]        = bus_g.byteenable;
            assign o_wd[gi]        = bus_g.writedata;

            mips_bus_sequencer #(
                .READ_LATENCY (rl_of(gi)),
                .MAX_WAIT     (mw_of(gi)),
                .ALIGN_CHECK  (ac_of(gi))
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus_g)
            );
        end
    endgenerate

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit model_err(int c, logic [1:0] sz, logic [31:0] ad);
        if (sz == 2'd3) return 1'b1;
        if (!ac_of(c)) return 1'b0;
        if (sz == 2'd1) return (ad % 2) != 0;
        if (sz == 2'd2) return (ad % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_be(logic [1:0] sz, logic [31:0] ad);
        int unsigned o = ad % 4;
        if (sz == 2'd0) return 4'(1 << o);
        if (sz == 2'd1) return (o >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wd(logic [1:0] sz, logic [31:0] wd);
        if (sz == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] sz, bit sg, logic [31:0] ad, logic [31:0] rd);
        int unsigned o = ad % 4;
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * o)) & 32'hFF;
            if (sg && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * (o / 2))) & 32'hFFFF;
            if (sg && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    task automatic set_idle(input int c);
        exp_ready[c]     = 1'b1;
        exp_rsp_valid[c] = 1'b0;
        exp_rsp_error[c] = 1'b0;
        exp_rdata[c]     = 32'd0;
        exp_read[c]      = 1'b0;
        exp_write[c]     = 1'b0;
        exp_address[c]   = 32'd0;
        exp_be[c]        = 4'd0;
        exp_wd[c]        = 32'd0;
    endtask

    // Compare every enabled configuration against the model on each falling edge.
    always @(negedge clk) begin
        for (int c = 0; c < NCFG; c++) begin
            if (chk_en[c]) begin
                check($sformatf("c%0d req_ready", c),  32'(o_ready[c]),     32'(exp_ready[c]));
                check($sformatf("c%0d rsp_valid", c),  32'(o_rsp_valid[c]), 32'(exp_rsp_valid[c]));
                check($sformatf("c%0d rsp_error", c),  32'(o_rsp_error[c]), 32'(exp_rsp_error[c]));
                check($sformatf("c%0d rsp_rdata", c),  o_rdata[c],          exp_rdata[c]);
                check($sformatf("c%0d read", c),       32'(o_read[c]),      32'(exp_read[c]));
                check($sformatf("c%0d write", c),      32'(o_write[c]),     32'(exp_write[c]));
                check($sformatf("c%0d address", c),    o_address[c],        exp_address[c]);
                check($sformatf("c%0d byteenable", c), 32'(o_be[c]),        32'(exp_be[c]));
                check($sformatf("c%0d writedata", c),  o_wd[c],             exp_wd[c]);
            end
        end
    end

    // Observations from the latest transaction, for the hand-computed checks.
    logic [31:0] obs_addr, obs_wd, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_write1, obs_err;
    int          obs_resp_k, obs_read_cnt;

    // One request on configuration c. Starts and ends just after a rising edge with the DUT idle.
    // stalls = waitrequest-high cycles before acceptance; rdword = data presented at capture time.
    task automatic run_txn(input int c, input bit wr, input logic [1:0] sz, input bit sg,
                           input logic [31:0] ad, input logic [31:0] wd, input int stalls,
                           input logic [31:0] rdword);
        int  m, l, bus_len, resp_k, cap_k;
        bit  err, tmo, in_bus;
        m       = int'(mw_of(c));
        l       = int'(rl_of(c));
        err     = model_err(c, sz, ad);
        tmo     = !err && m > 0 && stalls >= m;
        bus_len = err ? 0 : (tmo ? m : stalls + 1);
        resp_k  = err ? 1 : (tmo ? m + 1 : (wr ? stalls + 2 : stalls + 2 + l));
        cap_k   = stalls + 1 + l;
        obs_resp_k   = -1;
        obs_read_cnt = 0;
        obs_rdata    = 32'hx;
        obs_err      = 1'bx;

        // cycle 0: handshake
        req_valid[c]   = 1'b1;
        req_write[c]   = wr;
        req_size[c]    = sz;
        req_signed[c]  = sg;
        req_addr[c]    = ad;
        req_wdata[c]   = wd;
        waitrequest[c] = 1'($urandom % 2);
        readdata[c]    = $urandom;
        set_idle(c);
        @(posedge clk); #1;

        for (int k = 1; k <= resp_k; k++) begin
            req_valid[c]   = 1'($urandom % 2);
            req_write[c]   = 1'($urandom % 2);
            req_size[c]    = 2'($urandom % 4);
            req_signed[c]  = 1'($urandom % 2);
            req_addr[c]    = $urandom;
            req_wdata[c]   = $urandom;
            waitrequest[c] = (k <= stalls) ? 1'b1 : ((k == stalls + 1) ? 1'b0 : 1'($urandom % 2));
            readdata[c]    = (!err && !tmo && !wr && k == cap_k) ? rdword : $urandom;

            in_bus           = (k <= bus_len);
            exp_ready[c]     = 1'b0;
            exp_read[c]      = in_bus && !wr;
            exp_write[c]     = in_bus && wr;
            exp_address[c]   = in_bus ? (ad & 32'hFFFF_FFFC) : 32'd0;
            exp_be[c]        = in_bus ? model_be(sz, ad) : 4'd0;
            exp_wd[c]        = in_bus ? model_wd(sz, wd) : 32'd0;
            exp_rsp_valid[c] = (k == resp_k);
            exp_rsp_error[c] = (k == resp_k) && (err || tmo);
            exp_rdata[c]     = (k == resp_k && !err && !tmo && !wr) ? model_load(sz, sg, ad, rdword) : 32'd0;

            @(negedge clk);
            if (k == 1) begin
                obs_addr   = o_address[c];
                obs_be     = o_be[c];
                obs_wd     = o_wd[c];
                obs_write1 = o_write[c];
            end
            if (o_read[c]) obs_read_cnt++;
            if (o_rsp_valid[c] && obs_resp_k < 0) begin
                obs_resp_k = k;
                obs_rdata  = o_rdata[c];
                obs_err    = o_rsp_error[c];
            end
            @(posedge clk); #1;
        end
        req_valid[c] = 1'b0;
        set_idle(c);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int c = 0; c < NCFG; c++) begin
            req_valid[c] = 1'b0; req_write[c] = 1'b0; req_size[c] = 2'd0; req_signed[c] = 1'b0;
            req_addr[c] = 32'd0; req_wdata[c] = 32'd0; waitrequest[c] = 1'b0; readdata[c] = 32'd0;
            chk_en[c] = 1'b0;
            set_idle(c);
        end
        repeat (3) @(posedge clk);

        // Reset state: every output low, including req_ready.
        @(negedge clk);
        for (int c = 0; c < NCFG; c++) begin
            check($sformatf("c%0d reset req_ready", c), 32'(o_ready[c]), 32'd0);
            check($sformatf("c%0d reset rsp_valid", c), 32'(o_rsp_valid[c]), 32'd0);
            check($sformatf("c%0d reset read", c),      32'(o_read[c]), 32'd0);
            check($sformatf("c%0d reset write", c),     32'(o_write[c]), 32'd0);
            check($sformatf("c%0d reset address", c),   o_address[c], 32'd0);
            check($sformatf("c%0d reset byteenable", c), 32'(o_be[c]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < NCFG; c++) chk_en[c] = 1'b1;

        // ---- hand-computed cases, config 0: READ_LATENCY=2, MAX_WAIT=4, ALIGN_CHECK=1 ----
        run_txn(0, 1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'd0);
        check("word store address",   obs_addr, 32'h0000_1004);
        check("word store byteenable", 32'(obs_be), 32'hF);
        check("word store writedata", obs_wd, 32'hDEAD_BEEF);
        check("word store write at T+1", 32'(obs_write1), 32'd1);
        check("word store rsp cycle", 32'(obs_resp_k), 32'd2);
        check("word store rsp_error", 32'(obs_err), 32'd0);

        run_txn(0, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 0, 32'h80FF_0000);
        check("signed byte load rdata", obs_rdata, 32'hFFFF_FF80);
        check("signed byte load rsp cycle", 32'(obs_resp_k), 32'd4);
        run_txn(0, 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'd0, 0, 32'h80FF_0000);
        check("unsigned byte load rdata", obs_rdata, 32'h0000_0080);

        run_txn(0, 1'b1, 2'd1, 1'b0, 32'h0000_1236, 32'h0000_ABCD, 3, 32'd0);
        check("stalled half store byteenable", 32'(obs_be), 32'hC);
        check("stalled half store writedata", obs_wd, 32'hABCD_ABCD);
        check("stalled half store rsp cycle", 32'(obs_resp_k), 32'd5);

        run_txn(0, 1'b0, 2'd2, 1'b0, 32'h0000_1002, 32'd0, 0, 32'h1234_5678);
        check("misaligned word rsp cycle", 32'(obs_resp_k), 32'd1);
        check("misaligned word rsp_error", 32'(obs_err), 32'd1);
        check("misaligned word read cycles", 32'(obs_read_cnt), 32'd0);
        run_txn(0, 1'b0, 2'd3, 1'b0, 32'h0000_1000, 32'd0, 0, 32'h1234_5678);
        check("reserved size rsp_error", 32'(obs_err), 32'd1);
        check("reserved size read cycles", 32'(obs_read_cnt), 32'd0);

        run_txn(0, 1'b0, 2'd2, 1'b0, 32'h0000_2000, 32'd0, 6, 32'h5555_AAAA);
        check("timeout read cycles", 32'(obs_read_cnt), 32'd4);
        check("timeout rsp cycle", 32'(obs_resp_k), 32'd5);
        check("timeout rsp_error", 32'(obs_err), 32'd1);
        check("timeout rsp_rdata", obs_rdata, 32'd0);
        run_txn(0, 1'b1, 2'd2, 1'b0, 32'h0000_2004, 32'h0102_0304, 0, 32'd0);
        check("after timeout rsp cycle", 32'(obs_resp_k), 32'd2);
        check("after timeout rsp_error", 32'(obs_err), 32'd0);

        // ---- config 1: READ_LATENCY=0, MAX_WAIT=0, ALIGN_CHECK=0 ----
        run_txn(1, 1'b1, 2'd1, 1'b0, 32'h0000_1003, 32'h0000_BEEF, 0, 32'd0);
        check("unchecked half store byteenable", 32'(obs_be), 32'hC);
        check("unchecked half store writedata", obs_wd, 32'hBEEF_BEEF);
        check("unchecked half store rsp_error", 32'(obs_err), 32'd0);
        run_txn(1, 1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'd0, 1, 32'h8001_1234);
        check("zero-latency half load rdata", obs_rdata, 32'hFFFF_8001);
        check("zero-latency half load rsp cycle", 32'(obs_resp_k), 32'd3);

        // ---- random traffic on every configuration ----
        for (int c = 0; c < NCFG; c++) begin
            for (int i = 0; i < 60; i++) begin
                logic [1:0] sz;
                int unsigned r;
                int st;
                r  = $urandom % 8;
                sz = (r == 7) ? 2'd3 : 2'(r % 3);
                st = ($urandom % 3 == 0) ? int'($urandom_range(0, 6)) : 0;
                run_txn(c, 1'($urandom % 2), sz, 1'($urandom % 2), $urandom, $urandom, st, $urandom);
                idle_cycles(int'($urandom % 3));
            end
        end

        // ---- reset in the middle of a stalled read on config 0 ----
        for (int c = 0; c < NCFG; c++) chk_en[c] = 1'b0;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_size[0] = 2'd2;
        req_addr[0] = 32'h0000_3000; waitrequest[0] = 1'b1;
        @(negedge clk);
        check("pre-reset req_ready", 32'(o_ready[0]), 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("pre-reset read in BUS", 32'(o_read[0]), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset drops read", 32'(o_read[0]), 32'd0);
        check("reset clears req_ready", 32'(o_ready[0]), 32'd0);
        check("reset gives no rsp_valid", 32'(o_rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        waitrequest[0] = 1'b0;
        @(negedge clk);
        check("post-reset no rsp_valid", 32'(o_rsp_valid[0]), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        for (int c = 0; c < NCFG; c++) begin
            check($sformatf("c%0d req_ready after reset", c), 32'(o_ready[c]), 32'd1);
            set_idle(c);
            chk_en[c] = 1'b1;
        end
        @(posedge clk); #1;
        run_txn(0, 1'b0, 2'd0, 1'b0, 32'h0000_3001, 32'd0, 0, 32'h0000_7700);
        check("post-reset byte load rdata", obs_rdata, 32'h0000_0077);
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
